// File: rtl/alu.sv
// RV32 datapath ALU: combinational result/zero plus an optional N/Z/C/V status register.
// Build option: define ALU_FLAGREG_EN to implement flags_q; otherwise it is tied to zero.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flag_en,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero,
    output logic [3:0]       flags_q
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic             is_add;
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             c_flag;
    logic             v_flag;
    logic [3:0]       flags_d;

    // One adder serves ADD and SUB; SUB inverts B and injects the +1 as carry-in.
    assign is_add = (alucontrol == OP_ADD);
    assign is_sub = (alucontrol == OP_SUB);
    assign b_op   = is_sub ? ~srcb : srcb;
    assign sum    = {1'b0, srca} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

    // Result select; every code is defined so there is no X fallback.
    always_comb begin
        aluresult = '0;
        unique case (alucontrol)
            OP_ADD:  aluresult = sum[WIDTH-1:0];
            OP_SUB:  aluresult = sum[WIDTH-1:0];
            OP_AND:  aluresult = srca & srcb;
            OP_OR:   aluresult = srca | srcb;
            OP_XOR:  aluresult = srca ^ srcb;
            OP_SLTU: aluresult = {{(WIDTH-1){1'b0}}, (srca < srcb)};
            OP_SLL:  aluresult = srca << srcb[SW-1:0];
            OP_SLT:  aluresult = {{(WIDTH-1){1'b0}},
                                  ($signed(srca) < $signed(srcb))};
        endcase
    end

    assign zero = (aluresult == '0);

    // Overflow on the shared adder: same-sign inputs giving a different-sign sum.
    // With B inverted for SUB this is exactly the subtraction overflow rule.
    assign c_flag  = (is_add | is_sub) & sum[WIDTH];
    assign v_flag  = (is_add | is_sub)
                   & (srca[WIDTH-1] == b_op[WIDTH-1])
                   & (sum[WIDTH-1] != srca[WIDTH-1]);
    assign flags_d = {aluresult[WIDTH-1], zero, c_flag, v_flag};

`ifdef ALU_FLAGREG_EN
    // Status capture for debug/trace; reset wins over flag_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flag_en) begin
            flags_q <= flags_d;
        end
    end
`else
    assign flags_q = 4'b0000;

    logic unused_flagreg;
    assign unused_flagreg = &{1'b0, clk, reset, flag_en, flags_d, 1'b0};
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: results and flags queued at drive time, popped at sampling.
// Flag expectations collapse to zero unless ALU_FLAGREG_EN is defined.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [2:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flag_en;
    logic [31:0] aluresult;
    logic        zero;
    logic [3:0]  flags_q;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } res_t;

    res_t       res_q[$];
    logic [3:0] flg_q[$];

    int ntot = 0;
    int nbad = 0;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .flag_en    (flag_en),
        .aluresult  (aluresult),
        .zero       (zero),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef ALU_FLAGREG_EN
        return f;
`else
        return 4'b0000 & f;
`endif
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (a < b) ? 32'd1 : 32'd0;
            3'd6: r = a << b[4:0];
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] model_flg(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        logic [32:0] u;
        logic signed [32:0] s;
        logic c, v;
        r = model_res(op, a, b);
        c = 1'b0;
        v = 1'b0;
        if (op == 3'd0) begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[31], a}) + $signed({b[31], b});
            c = u[32];
            v = (s > 33'sd2147483647) || (s < -33'sd2147483648);
        end else if (op == 3'd1) begin
            s = $signed({a[31], a}) - $signed({b[31], b});
            c = (a >= b);
            v = (s > 33'sd2147483647) || (s < -33'sd2147483648);
        end
        return {r[31], (r == 32'd0), c, v};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic en);
        @(negedge clk);
        alucontrol = op;
        srca       = a;
        srcb       = b;
        flag_en    = en;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        flag_en = 1'b1;
        @(posedge clk);
        #1;
        flg_q.push_back(4'b0000);
        ntot++;
        if (flags_q !== flg_q.pop_front()) begin
            nbad++;
            $display("FAIL reset_flags got=%h want=0", flags_q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Directed vectors: drive, check result/zero, then check captured flags.
    task automatic run_table(input string name, input logic [2:0] op[],
                             input logic [31:0] a[], input logic [31:0] b[],
                             input logic [31:0] er[], input logic [3:0] ef[]);
        res_t e;
        logic [3:0] ee;
        for (int i = 0; i < op.size(); i++) begin
            drive(op[i], a[i], b[i], 1'b1);
            res_q.push_back('{res: er[i], z: (er[i] == 32'd0)});
            flg_q.push_back(fx(ef[i]));
            #1;
            e = res_q.pop_front();
            ntot++;
            if (aluresult !== e.res || zero !== e.z) begin
                nbad++;
                $display("FAIL %s[%0d] res got=%h/%b want=%h/%b",
                         name, i, aluresult, zero, e.res, e.z);
            end
            @(posedge clk);
            #1;
            ee = flg_q.pop_front();
            ntot++;
            if (flags_q !== ee) begin
                nbad++;
                $display("FAIL %s[%0d] flags got=%b want=%b",
                         name, i, flags_q, ee);
            end
        end
    endtask

    task automatic test_add;
        run_table("add", '{3'd0, 3'd0},
                  '{32'h7FFF_FFFF, 32'hFFFF_FFFF}, '{32'd1, 32'd1},
                  '{32'h8000_0000, 32'h0}, '{4'b1001, 4'b0110});
    endtask

    task automatic test_sub;
        run_table("sub", '{3'd1, 3'd1, 3'd1},
                  '{32'd5, 32'd3, 32'h8000_0000}, '{32'd5, 32'd5, 32'd1},
                  '{32'h0, 32'hFFFF_FFFE, 32'h7FFF_FFFF},
                  '{4'b0110, 4'b1000, 4'b0011});
    endtask

    task automatic test_logic;
        run_table("logic", '{3'd2, 3'd3, 3'd4, 3'd2},
                  '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234},
                  '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0},
                  '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'h0},
                  '{4'b0000, 4'b1000, 4'b1000, 4'b0100});
    endtask

    task automatic test_compare;
        run_table("cmp", '{3'd5, 3'd7, 3'd5, 3'd7},
                  '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1},
                  '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{32'd0, 32'd1, 32'd1, 32'd0},
                  '{4'b0100, 4'b0000, 4'b0000, 4'b0100});
    endtask

    task automatic test_sll;
        run_table("sll", '{3'd6, 3'd6},
                  '{32'h1, 32'h1}, '{32'h24, 32'h1F},
                  '{32'h10, 32'h8000_0000}, '{4'b0000, 4'b1000});
    endtask

    task automatic test_flag_hold;
        res_t e;
        logic [3:0] ee;
        drive(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
        @(posedge clk);
        drive(3'd1, 32'd3, 32'd5, 1'b1);
        reset = 1'b1;
        res_q.push_back('{res: 32'hFFFF_FFFE, z: 1'b0});
        flg_q.push_back(4'b0000);
        #1;
        e = res_q.pop_front();
        ntot++;
        if (aluresult !== e.res || zero !== e.z) begin
            nbad++;
            $display("FAIL rst_res got=%h want=%h", aluresult, e.res);
        end
        @(posedge clk);
        #1;
        ee = flg_q.pop_front();
        ntot++;
        if (flags_q !== ee) begin
            nbad++;
            $display("FAIL rst_clear got=%b want=%b", flags_q, ee);
        end
        ntot++;
        if (aluresult !== 32'hFFFF_FFFE) begin
            nbad++;
            $display("FAIL rst_track got=%h want=fffffffe", aluresult);
        end
        drive(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        drive(3'd1, 32'd5, 32'd5, 1'b0);
        flg_q.push_back(fx(4'b1001));
        @(posedge clk);
        #1;
        ee = flg_q.pop_front();
        ntot++;
        if (flags_q !== ee) begin
            nbad++;
            $display("FAIL hold got=%b want=%b", flags_q, ee);
        end
        ntot++;
        if (zero !== 1'b1) begin
            nbad++;
            $display("FAIL hold_zero got=%b want=1", zero);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  op;
        logic [31:0] a, b;
        res_t e;
        logic [3:0] ee;
        for (int i = 0; i < 64; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            drive(op, a, b, 1'b1);
            res_q.push_back('{res: model_res(op, a, b),
                              z: (model_res(op, a, b) == 32'd0)});
            flg_q.push_back(fx(model_flg(op, a, b)));
            #1;
            e = res_q.pop_front();
            ntot++;
            if (aluresult !== e.res || zero !== e.z) begin
                nbad++;
                $display("FAIL b2b[%0d] op=%0d res got=%h/%b want=%h/%b",
                         i, op, aluresult, zero, e.res, e.z);
            end
            @(posedge clk);
            #1;
            ee = flg_q.pop_front();
            ntot++;
            if (flags_q !== ee) begin
                nbad++;
                $display("FAIL b2b[%0d] op=%0d flags got=%b want=%b",
                         i, op, flags_q, ee);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        flag_en    = 1'b0;
        alucontrol = 3'd0;
        srca       = '0;
        srcb       = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_compare();
        test_sll();
        test_flag_hold();
        test_back_to_back();
        ntot++;
        if (res_q.size() != 0 || flg_q.size() != 0) begin
            nbad++;
            $display("FAIL scoreboard_left res=%0d flg=%0d want=0",
                     res_q.size(), flg_q.size());
        end
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
